// File: rtl/screen_director.sv
// Screen sequencer for the VGA path: owns the menu/play/pause/over state
// machine, picks which image pipeline feeds the DAC, and applies
// frame-synchronous fades when switching between full-screen images.
module screen_director #(
  parameter int H_LAST       = 799,
  parameter int V_LAST       = 524,
  parameter int FADE_FRAMES  = 2,
  parameter int OVER_TIMEOUT = 600
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        start_key,
  input  logic        pause_key,
  input  logic        game_over,
  input  logic [11:0] menu_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] over_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  screen_sel,
  output logic        game_run,
  output logic        frame_tick
);

  typedef enum logic [2:0] {
    ST_MENU,
    ST_FADE_OUT,
    ST_FADE_IN,
    ST_GAME,
    ST_PAUSE,
    ST_OVER
  } state_t;

  localparam logic [1:0]  SCR_MENU  = 2'd0;
  localparam logic [1:0]  SCR_GAME  = 2'd1;
  localparam logic [1:0]  SCR_OVER  = 2'd2;
  localparam logic [15:0] STEP_LAST = 16'(FADE_FRAMES - 1);
  localparam logic [15:0] OVER_LAST = 16'(OVER_TIMEOUT - 1);
  localparam logic [9:0]  X_LAST    = 10'(H_LAST);
  localparam logic [9:0]  Y_LAST    = 10'(V_LAST);

  state_t      state_q;
  logic [1:0]  target_q;      // screen encoding the current fade is heading to
  logic [4:0]  level_q;       // brightness 0..16
  logic [15:0] step_cnt_q;    // frames spent at the current fade level
  logic [15:0] over_cnt_q;    // frames spent on the game-over screen
  logic        start_key_q;
  logic        pause_key_q;
  logic        start_pend_q;
  logic        pause_pend_q;
  logic        frame_tick_q;
  logic [1:0]  screen_sel_q;
  logic        game_run_q;
  logic [11:0] pix_q;

  logic        start_rise_d;
  logic        pause_rise_d;
  logic        tick_d;
  logic [4:0]  lvl_d;
  logic [11:0] src_d;
  logic [11:0] pix_d;

  assign start_rise_d = start_key & ~start_key_q;
  assign pause_rise_d = pause_key & ~pause_key_q;
  assign tick_d       = (DrawX == X_LAST) && (DrawY == Y_LAST);
  // Pause dims the play-field to half brightness without touching the fade level.
  assign lvl_d        = (state_q == ST_PAUSE) ? 5'd8 : level_q;

  // Source image selection by the currently displayed screen.
  always_comb begin
    src_d = 12'h000;
    case (screen_sel_q)
      SCR_MENU: src_d = menu_rgb;
      SCR_GAME: src_d = game_rgb;
      SCR_OVER: src_d = over_rgb;
      default:  src_d = 12'h000;
    endcase
  end

  // Per-channel brightness scaling: (c * lvl) >> 4, 16 passes c unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign pix_d[gi*4 +: 4] =
        4'(({5'd0, src_d[gi*4 +: 4]} * {4'd0, lvl_d}) >> 4);
    end
  endgenerate

  // Key edge capture, frame tick, and the screen state machine (frame-tick driven).
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_MENU;
      target_q     <= SCR_MENU;
      level_q      <= 5'd16;
      step_cnt_q   <= '0;
      over_cnt_q   <= '0;
      start_key_q  <= 1'b0;
      pause_key_q  <= 1'b0;
      start_pend_q <= 1'b0;
      pause_pend_q <= 1'b0;
      frame_tick_q <= 1'b0;
      screen_sel_q <= SCR_MENU;
      game_run_q   <= 1'b0;
    end else begin
      start_key_q  <= start_key;
      pause_key_q  <= pause_key;
      frame_tick_q <= tick_d;
      if (frame_tick_q) begin
        // Pending key edges live for at most one frame; unused ones are dropped here.
        start_pend_q <= 1'b0;
        pause_pend_q <= 1'b0;
        case (state_q)
          ST_MENU: begin
            if (start_pend_q) begin
              state_q    <= ST_FADE_OUT;
              target_q   <= SCR_GAME;
              step_cnt_q <= '0;
            end
          end
          ST_FADE_OUT: begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= '0;
              level_q    <= level_q - 5'd1;
              if (level_q == 5'd1) begin
                // Swap images while the screen is fully black.
                screen_sel_q <= target_q;
                state_q      <= ST_FADE_IN;
              end
            end else begin
              step_cnt_q <= step_cnt_q + 16'd1;
            end
          end
          ST_FADE_IN: begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= '0;
              level_q    <= level_q + 5'd1;
              if (level_q == 5'd15) begin
                case (target_q)
                  SCR_GAME: begin
                    state_q    <= ST_GAME;
                    game_run_q <= 1'b1;
                  end
                  SCR_OVER: begin
                    state_q    <= ST_OVER;
                    over_cnt_q <= '0;
                  end
                  default: state_q <= ST_MENU;
                endcase
              end
            end else begin
              step_cnt_q <= step_cnt_q + 16'd1;
            end
          end
          ST_GAME: begin
            // Game over outranks a pause request in the same frame.
            if (game_over) begin
              game_run_q <= 1'b0;
              state_q    <= ST_FADE_OUT;
              target_q   <= SCR_OVER;
              step_cnt_q <= '0;
            end else if (pause_pend_q) begin
              game_run_q <= 1'b0;
              state_q    <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (pause_pend_q) begin
              game_run_q <= 1'b1;
              state_q    <= ST_GAME;
            end
          end
          ST_OVER: begin
            if (start_pend_q || (over_cnt_q == OVER_LAST)) begin
              state_q    <= ST_FADE_OUT;
              target_q   <= SCR_MENU;
              step_cnt_q <= '0;
            end else begin
              over_cnt_q <= over_cnt_q + 16'd1;
            end
          end
          default: begin
            state_q    <= ST_MENU;
            game_run_q <= 1'b0;
          end
        endcase
      end else begin
        if (start_rise_d) start_pend_q <= 1'b1;
        if (pause_rise_d) pause_pend_q <= 1'b1;
      end
    end
  end

  // Registered pixel output, forced black outside the active region.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      pix_q <= 12'h000;
    end else begin
      pix_q <= blank ? pix_d : 12'h000;
    end
  end

  assign red        = pix_q[11:8];
  assign green      = pix_q[7:4];
  assign blue       = pix_q[3:0];
  assign screen_sel = screen_sel_q;
  assign game_run   = game_run_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_screen_director.sv
// Bench for screen_director: short synthetic frames (the bench jumps straight
// to the last pixel) with a frame-level behavioural model of the screen flow.
module tb_screen_director;

  localparam int TB_FF = 1;
  localparam int TB_OT = 3;
  localparam int HL    = 799;
  localparam int VL    = 524;

  localparam int MD_MENU  = 0;
  localparam int MD_GAME  = 1;
  localparam int MD_OVER  = 2;
  localparam int MD_PAUSE = 3;
  localparam int MD_FADE  = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, start_key, pause_key, game_over;
  logic [11:0] menu_rgb, game_rgb, over_rgb;
  logic [3:0]  red, green, blue;
  logic [1:0]  screen_sel;
  logic        game_run, frame_tick;

  int total = 0;
  int bad   = 0;

  // Model: which screen is up, its brightness and the remaining fade schedule.
  int m_mode, m_level, m_scr, m_over, m_dest;
  bit m_run;
  int fq_lvl[$];
  int fq_scr[$];

  always #5 clk = ~clk;

  screen_director #(
    .H_LAST(HL), .V_LAST(VL), .FADE_FRAMES(TB_FF), .OVER_TIMEOUT(TB_OT)
  ) dut (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .start_key(start_key), .pause_key(pause_key), .game_over(game_over),
    .menu_rgb(menu_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
    .red(red), .green(green), .blue(blue), .screen_sel(screen_sel),
    .game_run(game_run), .frame_tick(frame_tick)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] scale12(input logic [11:0] c, input int lvl);
    logic [11:0] r;
    r = 12'h000;
    for (int i = 0; i < 3; i++) begin
      int ch;
      ch = int'(c[i*4 +: 4]);
      r[i*4 +: 4] = 4'((ch * lvl) / 16);
    end
    return r;
  endfunction

  function automatic logic [11:0] model_pixel();
    logic [11:0] src;
    int lvl;
    case (m_scr)
      0: src = menu_rgb;
      1: src = game_rgb;
      2: src = over_rgb;
      default: src = 12'h000;
    endcase
    lvl = (m_mode == MD_PAUSE) ? 8 : m_level;
    return scale12(src, lvl);
  endfunction

  task automatic model_reset();
    m_mode = MD_MENU; m_level = 16; m_scr = 0; m_over = 0; m_dest = 0; m_run = 1'b0;
    fq_lvl.delete(); fq_scr.delete();
  endtask

  // A fade is a precomputed schedule of (level, screen) for each coming frame.
  task automatic begin_fade(input int dest);
    m_mode = MD_FADE;
    m_dest = dest;
    fq_lvl.delete(); fq_scr.delete();
    for (int k = 1; k <= 32 * TB_FF; k++) begin
      if (k <= 16 * TB_FF) begin
        fq_lvl.push_back(16 - k / TB_FF);
        fq_scr.push_back((k == 16 * TB_FF) ? dest : m_scr);
      end else begin
        fq_lvl.push_back((k - 16 * TB_FF) / TB_FF);
        fq_scr.push_back(dest);
      end
    end
  endtask

  task automatic model_tick(input bit sp, input bit pp, input bit go);
    case (m_mode)
      MD_MENU: if (sp) begin_fade(MD_GAME);
      MD_FADE: begin
        m_level = fq_lvl.pop_front();
        m_scr   = fq_scr.pop_front();
        if (fq_lvl.size() == 0) begin
          m_mode = m_dest;
          m_run  = (m_dest == MD_GAME);
          m_over = 0;
        end
      end
      MD_GAME: begin
        if (go) begin
          m_run = 1'b0;
          begin_fade(MD_OVER);
        end else if (pp) begin
          m_run  = 1'b0;
          m_mode = MD_PAUSE;
        end
      end
      MD_PAUSE: if (pp) begin m_mode = MD_GAME; m_run = 1'b1; end
      MD_OVER: begin
        if (sp || m_over == TB_OT - 1) begin_fade(MD_MENU);
        else m_over++;
      end
      default: ;
    endcase
  endtask

  // One synthetic frame: pixel checks, optional key edges, then the frame boundary.
  task automatic do_frame(input bit sp, input bit pp, input bit go,
                          input bit force_en, input logic [11:0] force_rgb,
                          input string tag);
    logic [11:0] exp_pix;
    DrawX = 10'($urandom_range(0, HL - 1));
    DrawY = 10'($urandom_range(0, VL));
    blank = 1'b1;
    game_over = go;
    if (force_en) begin
      menu_rgb = force_rgb; game_rgb = force_rgb; over_rgb = force_rgb;
    end else begin
      menu_rgb = 12'($urandom); game_rgb = 12'($urandom); over_rgb = 12'($urandom);
    end
    cycle();
    exp_pix = model_pixel();
    total++;
    if ({red, green, blue} !== exp_pix) begin
      bad++;
      $display("FAIL %s pixel: got %h expected %h (level %0d screen %0d)",
               tag, {red, green, blue}, exp_pix, m_level, m_scr);
    end
    blank = 1'b0;
    cycle();
    blank = 1'b1;
    total++;
    if ({red, green, blue} !== 12'h000 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL %s blanked: got rgb=%h tick=%b expected rgb=000 tick=0",
               tag, {red, green, blue}, frame_tick);
    end
    if (sp) begin start_key = 1'b1; cycle(); start_key = 1'b0; end
    if (pp) begin pause_key = 1'b1; cycle(); pause_key = 1'b0; end
    repeat ($urandom_range(0, 2)) cycle();
    DrawX = 10'(HL); DrawY = 10'(VL);
    cycle();
    total++;
    if (frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL %s frame_tick: got %b expected 1", tag, frame_tick);
    end
    DrawX = 10'($urandom_range(0, HL - 1));
    cycle();
    model_tick(sp, pp, go);
    total++;
    if (screen_sel !== 2'(m_scr) || game_run !== m_run || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL %s after tick: got sel=%0d run=%b tick=%b expected sel=%0d run=%b tick=0",
               tag, screen_sel, game_run, frame_tick, m_scr, m_run);
    end
    $display("frame %s sp=%b pp=%b go=%b -> sel=%0d run=%b rgb=%h",
             tag, sp, pp, go, screen_sel, game_run, {red, green, blue});
  endtask

  task automatic test_reset();
    Reset = 1'b1; start_key = 1'b0; pause_key = 1'b0; game_over = 1'b0;
    blank = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    menu_rgb = 12'hF84; game_rgb = 12'h123; over_rgb = 12'h456;
    #1;
    model_reset();
    total++;
    if ({red, green, blue} !== 12'h000 || game_run !== 1'b0 ||
        screen_sel !== 2'd0 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got rgb=%h run=%b sel=%0d tick=%b expected 000/0/0/0",
               {red, green, blue}, game_run, screen_sel, frame_tick);
    end
    cycle(); cycle();
    Reset = 1'b0;
    cycle();
    total++;
    if ({red, green, blue} !== 12'hF84 || game_run !== 1'b0 || screen_sel !== 2'd0) begin
      bad++;
      $display("FAIL reset_menu_pixel: got rgb=%h run=%b sel=%0d expected F84/0/0",
               {red, green, blue}, game_run, screen_sel);
    end
    $display("reset done rgb=%h", {red, green, blue});
  endtask

  task automatic test_fade_to_game();
    do_frame(1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, "menu_start");
    for (int f = 0; f < 32; f++)
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
               1'b1, 12'hFFF, "fade_to_game");
    total++;
    if (game_run !== 1'b1 || screen_sel !== 2'd1) begin
      bad++;
      $display("FAIL enter_game: got run=%b sel=%0d expected 1/1", game_run, screen_sel);
    end
  endtask

  task automatic test_pause();
    int half;
    half = (15 * 8) / 16;
    do_frame(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, "pause_on");
    do_frame(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, "pause_ignore_over");
    cycle();
    total++;
    if ({red, green, blue} !== {4'(half), 4'(half), 4'(half)} || game_run !== 1'b0) begin
      bad++;
      $display("FAIL pause_dim: got rgb=%h run=%b expected %0h%0h%0h run=0",
               {red, green, blue}, game_run, half, half, half);
    end
    do_frame(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, "pause_off");
    cycle();
    total++;
    if ({red, green, blue} !== 12'hFFF || game_run !== 1'b1) begin
      bad++;
      $display("FAIL resume_full: got rgb=%h run=%b expected FFF run=1",
               {red, green, blue}, game_run);
    end
  endtask

  task automatic test_game_over_priority();
    do_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "over_vs_pause");
    total++;
    if (game_run !== 1'b0) begin
      bad++;
      $display("FAIL over_priority_run: got %b expected 0", game_run);
    end
    for (int f = 0; f < 32; f++)
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 12'h000, "fade_to_over");
    total++;
    if (screen_sel !== 2'd2 || game_run !== 1'b0) begin
      bad++;
      $display("FAIL enter_over: got sel=%0d run=%b expected 2/0", screen_sel, game_run);
    end
  endtask

  task automatic test_over_timeout();
    for (int f = 0; f < TB_OT; f++)
      do_frame(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, "over_wait");
    for (int f = 0; f < 32; f++)
      do_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 12'h000, "fade_to_menu");
    for (int f = 0; f < 3; f++)
      do_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "menu_idle");
    total++;
    if (screen_sel !== 2'd0 || game_run !== 1'b0) begin
      bad++;
      $display("FAIL back_in_menu: got sel=%0d run=%b expected 0/0", screen_sel, game_run);
    end
  endtask

  task automatic test_reset_mid_fade();
    do_frame(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "start_again");
    for (int f = 0; f < 25; f++)
      do_frame(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, "fade_to_lvl9");
    DrawX = 10'd5;
    Reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({red, green, blue} !== 12'h000 || game_run !== 1'b0 || screen_sel !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_fade: got rgb=%h run=%b sel=%0d expected 000/0/0",
               {red, green, blue}, game_run, screen_sel);
    end
    cycle();
    Reset = 1'b0;
    menu_rgb = 12'hF84; blank = 1'b1;
    cycle();
    total++;
    if ({red, green, blue} !== 12'hF84) begin
      bad++;
      $display("FAIL post_reset_level: got rgb=%h expected F84", {red, green, blue});
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 250; f++) begin
      bit sp, pp, go;
      sp = ($urandom_range(0, 5) == 0);
      pp = ($urandom_range(0, 3) == 0);
      go = (m_mode == MD_GAME) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      do_frame(sp, pp, go, 1'b0, 12'h000, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fade_to_game();
    test_pause();
    test_game_over_priority();
    test_over_timeout();
    test_reset_mid_fade();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
